// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================
// key_event_pkg : FSM state encoding and hold-counter width
//                 shared by the key event decoder.
// Rev 1.0
// ============================================================
package key_event_pkg;

    localparam int HOLD_W = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESSED   = 2'd1;
    localparam logic [1:0] ST_LONG_HELD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================
// ms_tick_gen : one-cycle tick every DIV enabled clocks; the
//               count restarts whenever en is low.
// Rev 1.0
// ============================================================
module ms_tick_gen #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================
// key_event_decoder : press / release / long-press / auto-repeat
//                     pulses from a debounced active-low key.
// Optional: define KEY_AUTO_REPEAT_EN for repeat pulses.
// Rev 1.0
// ============================================================
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_held
);

    localparam int TICK_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;

    // Thresholds fire on the tick that would make the count equal to the limit
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MS - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_MS - 1);
`else
    localparam int unused_repeat_ms = REPEAT_MS;
`endif

    logic              sync1;
    logic              sync2;
    logic              hist;
    logic              fall_edge;
    logic              rise_edge;
    state_t            state;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_d;
    logic              tick_en;
    logic              tick;
    logic              press_d;
    logic              release_d;
    logic              long_d;
    logic              repeat_d;

    // Reset to the released level so no edge is seen on reset exit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= key_level;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign fall_edge = hist & ~sync2;
    assign rise_edge = ~hist & sync2;
    assign tick_en   = (state != ST_IDLE);

    ms_tick_gen #(
        .DIV (TICK_DIV)
    ) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_d   = state;
        hold_d    = hold_cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall_edge) begin
                    press_d = 1'b1;
                    state_d = ST_PRESSED;
                    hold_d  = '0;
                end
            end
            ST_PRESSED: begin
                if (rise_edge) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                    hold_d    = '0;
                end else if (tick) begin
                    if (hold_cnt == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = ST_LONG_HELD;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (rise_edge) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                    hold_d    = '0;
                end
`ifdef KEY_AUTO_REPEAT_EN
                else if (tick) begin
                    if (hold_cnt == REP_LAST) begin
                        repeat_d = 1'b1;
                        hold_d   = '0;
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            key_held      <= 1'b0;
        end else begin
            state         <= state_d;
            hold_cnt      <= hold_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
            key_held      <= (state_d != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================
// tb_key_event_decoder : scoreboard bench; expected pulses are
//                        derived from key timing per press episode.
// Rev 1.0
// ============================================================
module tb_key_event_decoder;

    localparam int CLK_FREQ  = 10_000;
    localparam int LONG_MS   = 5;
    localparam int REPEAT_MS = 2;
    localparam int MS_CLK    = CLK_FREQ / 1000;
    localparam int LONG_CLK  = LONG_MS * MS_CLK;
    localparam int REP_CLK   = REPEAT_MS * MS_CLK;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       edge_no;
    } ev_t;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic key_level = 1'b1;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic key_held;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;

    key_event_decoder #(
        .CLK_FREQ  (CLK_FREQ),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .key_held      (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Press reported at p, release at r; timed events fire only strictly before release
    function automatic void push_episode(input int p, input int r);
        int t;
        exp_q.push_back('{EV_PRESS, p});
        if (p + LONG_CLK < r) begin
            exp_q.push_back('{EV_LONG, p + LONG_CLK});
            if (REP_EN) begin
                t = p + LONG_CLK + REP_CLK;
                while (t < r) begin
                    exp_q.push_back('{EV_REPEAT, t});
                    t += REP_CLK;
                end
            end
        end
        exp_q.push_back('{EV_RELEASE, r});
    endfunction

    task automatic run_press(input int gap, input int low_len);
        int p;
        repeat (gap) @(negedge clk);
        p = cyc + 3;
        push_episode(p, p + low_len);
        key_level = 1'b0;
        repeat (low_len) @(negedge clk);
        key_level = 1'b1;
    endtask

    task automatic run_reset_mid(input int gap, input int pre, input int post);
        int p;
        repeat (gap) @(negedge clk);
        p = cyc + 3;
        exp_q.push_back('{EV_PRESS, p});
        key_level = 1'b0;
        repeat (3 + pre) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        p = cyc + 3;
        push_episode(p, p + post);
        repeat (post) @(negedge clk);
        key_level = 1'b1;
    endtask

    always begin : monitor
        int       n_hot;
        ev_kind_t got;
        ev_t      e;
        @(posedge clk);
        #2;
        if (!rst) begin
            n_checks++;
            if ({press_pulse, release_pulse, long_pulse, repeat_pulse, key_held} != 5'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b, required 00000", cyc,
                         {press_pulse, release_pulse, long_pulse, repeat_pulse, key_held});
            end
        end else begin
            while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_%s: expected at cycle %0d, still absent at %0d",
                         e.kind.name(), e.edge_no, cyc);
            end
            n_hot = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
            if (n_hot > 1) begin
                n_checks++;
                n_fail++;
                $display("FAIL one_hot cycle %0d: got %0d pulses, required at most 1", cyc, n_hot);
            end else if (n_hot == 1) begin
                got = press_pulse   ? EV_PRESS   :
                      release_pulse ? EV_RELEASE :
                      long_pulse    ? EV_LONG    : EV_REPEAT;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cycle %0d: got %s, required none", cyc, got.name());
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != got || e.edge_no != cyc) begin
                        n_fail++;
                        $display("FAIL event_match: got %s at %0d, required %s at %0d",
                                 got.name(), cyc, e.kind.name(), e.edge_no);
                    end
                end
                n_checks++;
                if (key_held != (got != EV_RELEASE)) begin
                    n_fail++;
                    $display("FAIL key_held cycle %0d with %s: got %b, required %b",
                             cyc, got.name(), key_held, got != EV_RELEASE);
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_%s cycle %0d: got no pulse, required one", e.kind.name(), cyc);
            end
        end
    end

    initial begin
        rst       = 1'b0;
        key_level = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;

        run_press(6, 30);        // short press
        run_press(6, 120);       // long hold with repeats
        run_press(6, 50);        // release collides with long threshold
        run_press(6, 49);        // just under threshold
        run_reset_mid(6, 20, 70);
        run_press(3, 1);         // single-cycle glitch
        run_press(2, 90);        // release collides with a repeat
        for (int i = 0; i < 25; i++) begin
            run_press($urandom_range(2, 15), $urandom_range(1, 200));
        end

        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding events, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter LONG_MS, default 1000, meaning hold time in ms before a long-press event (range 1..65535).
REQ-003 SHALL have parameter REPEAT_MS, default 200, meaning the auto-repeat period in ms after a long press (range 1..65535).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port key_level, input, 1 bit: debounced key level, active-low (1 = released), asynchronous to clk.
REQ-007 SHALL have port press_pulse, output, 1 bit: one-cycle pulse on press.
REQ-008 SHALL have port release_pulse, output, 1 bit: one-cycle pulse on release.
REQ-009 SHALL have port long_pulse, output, 1 bit: one-cycle pulse when the hold reaches LONG_MS.
REQ-010 SHALL have port repeat_pulse, output, 1 bit: one-cycle pulse every REPEAT_MS after long_pulse.
REQ-011 SHALL have port key_held, output, 1 bit: 1 while the FSM is in PRESSED or LONG_HELD.

Function
REQ-012 SHALL pass key_level through a 2-flop synchronizer followed by a third history flop, with edges detected between stage 2 and the history flop.
REQ-013 SHALL register all outputs so that every pulse is high for exactly one clk.
REQ-014 SHALL assert press_pulse or release_pulse on the 3rd rising clk edge after the corresponding key_level transition.
REQ-015 SHALL implement FSM states IDLE, PRESSED and LONG_HELD.
REQ-016 SHALL, on a falling edge in IDLE: assert press_pulse, go to PRESSED, and clear the ms prescaler and the hold counter.
REQ-017 SHALL generate a 1 ms tick every CLK_FREQ/1000 clks from a prescaler that runs only while the FSM is not in IDLE.
REQ-018 SHALL use a 16-bit hold counter that increments on each tick.
REQ-019 SHALL, in PRESSED when the hold counter reaches LONG_MS: assert long_pulse, go to LONG_HELD, and clear the hold counter.
REQ-020 SHALL, in LONG_HELD when the hold counter reaches REPEAT_MS: assert repeat_pulse and clear the hold counter; this repeats until release.
REQ-021 SHALL, on a rising edge in PRESSED or LONG_HELD: assert release_pulse, go to IDLE, and clear both counters.
REQ-022 SHALL give release priority when a release and a threshold occur in the same cycle: release_pulse only, no long_pulse or repeat_pulse.
REQ-023 SHALL ignore a rising edge in IDLE and a falling edge outside IDLE (no pulse, no state change).
REQ-024 SHALL never assert more than one pulse output in the same cycle.

Reset
REQ-025 SHALL, while rst=0: force all outputs to 0, the FSM to IDLE, both counters to 0, and all three synchronizer/history flops to 1.
REQ-026 SHALL, when reset is applied mid-press, discard the press without emitting release_pulse.
REQ-027 SHALL, if key_level is still 0 after reset deasserts, emit press_pulse on the 3rd rising edge after the deassertion.

Configuration
REQ-028 SHALL, with macro KEY_AUTO_REPEAT_EN defined, provide the LONG_HELD repeat behaviour of REQ-020.
REQ-029 SHALL, without KEY_AUTO_REPEAT_EN, tie repeat_pulse to 0, stop the hold counter in LONG_HELD, and leave all other behaviour unchanged.

Structure
REQ-030 SHALL take the FSM state enumeration and the 16-bit hold-counter width constant from shared package key_event_pkg.
REQ-031 SHALL implement the ms prescaler as sub-module ms_tick_gen (inputs clk, rst, en; output tick); that module SHALL clear its count when en=0.

Verification
Bench parameters: CLK_FREQ=10_000, LONG_MS=5, REPEAT_MS=2, so 1 ms = 10 clk.
REQ-032 SHALL verify a short press: key_level low for 30 clk, then high -> press_pulse at edge 3, release_pulse 3 edges after the rise, no long_pulse.
REQ-033 SHALL verify a long hold (KEY_AUTO_REPEAT_EN defined): key_level held low for 120 clk -> long_pulse 50 clk after press_pulse, then repeat_pulse every 20 clk (3 pulses), then release_pulse.
REQ-034 SHALL verify the same 120 clk hold without KEY_AUTO_REPEAT_EN -> long_pulse only, repeat_pulse stays 0, then release_pulse.
REQ-035 SHALL verify the collision case: release timed so the synchronized rise coincides with the 50th clk of hold -> release_pulse asserted, long_pulse never asserted.
REQ-036 SHALL verify reset mid-hold: rst pulled low 20 clk into a press with key still low -> outputs 0, no release_pulse, press_pulse 3 edges after rst rises.
REQ-037 SHALL verify the sub-threshold case: key_level low for 49 clk after press_pulse -> no long_pulse, key_held falls with release_pulse.
